// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus sequencer.
package rtc_bus_pkg;

  // Bus phases; StIdle doubles as the arbitration point between transactions.
  typedef enum logic [3:0] {
    StIdle,
    StAddrSu,
    StAddrSt,
    StAddrHd,
    StGap,
    StDataSu,
    StDataSt,
    StDataHd,
    StRecover
  } state_e;

  // Kind of the transaction currently on the bus.
  typedef enum logic [1:0] {
    TxWrData,
    TxWrCmd,
    TxRdCmd,
    TxRdData
  } tx_kind_e;

  localparam logic [7:0] CMD_RD_XFER = 8'hF0;
  localparam logic [7:0] CMD_WR_XFER = 8'hF1;
  localparam int unsigned N_SCAN = 9;

  // Scan order: sec, min, hour, day, month, year, timer s/m/h.
  function automatic logic [7:0] scan_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h41;
      4'd7:    a = 8'h42;
      4'd8:    a = 8'h43;
      default: a = 8'h21;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Requester and RTC pin bundle for the bus sequencer.
interface rtc_bus_sequencer_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       rd_valid;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       rtc_cs_n;
  logic       rtc_rd_n;
  logic       rtc_wr_n;
  logic       rtc_ad;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  // Requester / RTC side.
  modport master (
    output wr_req, wr_addr, wr_data, ad_in,
    input  wr_ack, rd_valid, rd_addr, rd_data, busy,
    input  rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_out, ad_oe
  );

  // Sequencer side.
  modport slave (
    input  wr_req, wr_addr, wr_data, ad_in,
    output wr_ack, rd_valid, rd_addr, rd_data, busy,
    output rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_out, ad_oe
  );
endinterface

// File: rtl/rtc_tick_gen.sv
// Free-running period counter; o_tick is high for one cycle per SCAN_PERIOD.
module rtc_tick_gen #(
  parameter int unsigned SCAN_PERIOD = 2000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);
  localparam int unsigned CntW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  logic [CntW-1:0] r_cnt;
  logic            w_tc;

  assign w_tc   = (r_cnt == CntW'(SCAN_PERIOD - 1));
  assign o_tick = w_tc;

  // Wrap at terminal count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences RTC bus transactions for keyboard writes and the periodic read scan.
module rtc_bus_sequencer #(
  parameter int unsigned PHASE_CYC   = 4,
  parameter int unsigned SCAN_PERIOD = 2000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  rtc_bus_sequencer_if.slave io_bus
);
  import rtc_bus_pkg::*;

  localparam int unsigned PhW = $clog2(PHASE_CYC);

  state_e         r_state, w_state_next;
  tx_kind_e       r_kind;
  logic [PhW-1:0] r_phase;
  logic [7:0]     r_addr, r_wdata, r_sample, r_rd_addr, r_rd_data;
  logic           r_wr_ack, r_wr_armed, r_scan_pend, r_scan_act, r_need_f0;
  logic [3:0]     r_scan_idx;

  logic w_tick, w_phase_done, w_go, w_txn_end, w_is_read, w_is_cmd;
  logic w_start_wr, w_start_resume, w_start_rd, w_start_scan, w_start_any;

  rtc_tick_gen #(
    .SCAN_PERIOD(SCAN_PERIOD)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_tick (w_tick)
  );

  assign w_phase_done = (r_phase == PhW'(PHASE_CYC - 1));
  assign w_txn_end    = (r_state == StRecover) && w_phase_done;
  assign w_is_read    = (r_kind == TxRdData);
  assign w_is_cmd     = (r_kind == TxWrCmd) || (r_kind == TxRdCmd);

  // IDLE also lasts at least one phase, so decisions are taken on its last cycle.
  assign w_go           = (r_state == StIdle) && w_phase_done;
  assign w_start_wr     = w_go && io_bus.wr_req && r_wr_armed;
  assign w_start_resume = w_go && !w_start_wr && r_scan_act && r_need_f0;
  assign w_start_rd     = w_go && !w_start_wr && r_scan_act && !r_need_f0;
  assign w_start_scan   = w_go && !w_start_wr && !r_scan_act && r_scan_pend;
  assign w_start_any    = w_start_wr || w_start_resume || w_start_rd || w_start_scan;

  // FSM state register and phase counter (saturates in IDLE).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_phase <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_phase <= '0;
      end else if (!w_phase_done) begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  // Next-state: step through phases; a write chains straight into its F1 command.
  always_comb begin
    w_state_next = r_state;
    if (r_state == StIdle) begin
      if (w_start_any) w_state_next = StAddrSu;
    end else if (w_phase_done) begin
      case (r_state)
        StAddrSu:  w_state_next = StAddrSt;
        StAddrSt:  w_state_next = StAddrHd;
        StAddrHd:  w_state_next = w_is_cmd ? StRecover : StGap;
        StGap:     w_state_next = StDataSu;
        StDataSu:  w_state_next = StDataSt;
        StDataSt:  w_state_next = StDataHd;
        StDataHd:  w_state_next = StRecover;
        StRecover: w_state_next = (r_kind == TxWrData) ? StAddrSu : StIdle;
        default:   w_state_next = StIdle;
      endcase
    end
  end

  // Bus pin levels decoded from the current phase.
  always_comb begin
    io_bus.rtc_cs_n = 1'b1;
    io_bus.rtc_rd_n = 1'b1;
    io_bus.rtc_wr_n = 1'b1;
    io_bus.rtc_ad   = 1'b1;
    io_bus.ad_oe    = 1'b0;
    io_bus.ad_out   = 8'h00;
    case (r_state)
      StAddrSu, StAddrHd: begin
        io_bus.rtc_ad = 1'b0;
        io_bus.ad_oe  = 1'b1;
        io_bus.ad_out = r_addr;
      end
      StAddrSt: begin
        io_bus.rtc_cs_n = 1'b0;
        io_bus.rtc_wr_n = 1'b0;
        io_bus.rtc_ad   = 1'b0;
        io_bus.ad_oe    = 1'b1;
        io_bus.ad_out   = r_addr;
      end
      StDataSu, StDataHd: begin
        io_bus.ad_oe  = !w_is_read;
        io_bus.ad_out = w_is_read ? 8'h00 : r_wdata;
      end
      StDataSt: begin
        io_bus.rtc_cs_n = 1'b0;
        io_bus.rtc_wr_n = w_is_read;
        io_bus.rtc_rd_n = !w_is_read;
        io_bus.ad_oe    = !w_is_read;
        io_bus.ad_out   = w_is_read ? 8'h00 : r_wdata;
      end
      default: ;
    endcase
  end

  assign io_bus.rd_valid = (r_state == StRecover) && (r_phase == '0) && w_is_read;
  assign io_bus.rd_addr  = r_rd_addr;
  assign io_bus.rd_data  = r_rd_data;
  assign io_bus.wr_ack   = r_wr_ack;
  assign io_bus.busy     = (r_state != StIdle) || r_scan_act;

  // Transaction setup, read capture and write acknowledge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kind    <= TxRdCmd;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_sample  <= 8'h00;
      r_rd_addr <= 8'h00;
      r_rd_data <= 8'h00;
      r_wr_ack  <= 1'b0;
    end else begin
      if (w_start_wr) begin
        r_kind  <= TxWrData;
        r_addr  <= io_bus.wr_addr;
        r_wdata <= io_bus.wr_data;
      end else if (w_start_resume || w_start_scan) begin
        r_kind <= TxRdCmd;
        r_addr <= CMD_RD_XFER;
      end else if (w_start_rd) begin
        r_kind <= TxRdData;
        r_addr <= scan_addr(r_scan_idx);
      end else if (w_txn_end && (r_kind == TxWrData)) begin
        r_kind <= TxWrCmd;
        r_addr <= CMD_WR_XFER;
      end
      if ((r_state == StDataSt) && w_phase_done && w_is_read) r_sample <= io_bus.ad_in;
      if ((r_state == StDataHd) && w_phase_done && w_is_read) begin
        r_rd_addr <= r_addr;
        r_rd_data <= r_sample;
      end
      r_wr_ack <= w_txn_end && (r_kind == TxWrCmd);
    end
  end

  // Scan bookkeeping; a write that lands mid-scan forces a fresh F0 before resuming.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan_pend <= 1'b0;
      r_scan_act  <= 1'b0;
      r_scan_idx  <= 4'd0;
      r_need_f0   <= 1'b0;
    end else begin
      if (w_tick) begin
        r_scan_pend <= 1'b1;
      end else if (w_start_scan) begin
        r_scan_pend <= 1'b0;
      end
      if (w_start_scan) begin
        r_scan_act <= 1'b1;
        r_scan_idx <= 4'd0;
        r_need_f0  <= 1'b0;
      end else begin
        if (w_start_resume) r_need_f0 <= 1'b0;
        if (w_txn_end && (r_kind == TxWrCmd) && r_scan_act) r_need_f0 <= 1'b1;
        if (w_txn_end && w_is_read) begin
          if (r_scan_idx == 4'(N_SCAN - 1)) begin
            r_scan_act <= 1'b0;
            r_scan_idx <= 4'd0;
          end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
          end
        end
      end
    end
  end

  // A held wr_req fires once; it must be seen low before another write is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_armed <= 1'b1;
    end else if (w_start_wr) begin
      r_wr_armed <= 1'b0;
    end else if (!io_bus.wr_req) begin
      r_wr_armed <= 1'b1;
    end
  end
endmodule
